// File: rtl/ex_stage_pipe_if.sv
// Handshake and decoded-field bundle between the issue side, ex_stage_pipe and the consumer.
// The slave modport is the execute stage; the master modport is the upstream/downstream environment.
interface ex_stage_pipe_if #(
  parameter int CTRL_W = 17
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] control_signals;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] control_signals_out;
  logic [2:0]        alu_op_out;
  logic [2:0]        source_operand_out;
  logic              load_instr_out;
  logic              rf_enable_out;
  logic              branch_out;
  logic              busy;

  modport master (
    output in_valid, control_signals, flush, out_ready,
    input  in_ready, out_valid, control_signals_out, alu_op_out,
           source_operand_out, load_instr_out, rf_enable_out, branch_out, busy
  );

  modport slave (
    input  in_valid, control_signals, flush, out_ready,
    output in_ready, out_valid, control_signals_out, alu_op_out,
           source_operand_out, load_instr_out, rf_enable_out, branch_out, busy
  );
endinterface

// File: rtl/ex_stage_pipe.sv
// Single-entry execute stage: holds one control word, stalls MC_OP words for MC_LAT cycles,
// and presents the word with its decoded fields until the consumer takes it.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | empty, ready to accept a word
//   S_EXEC | multi-cycle op counting down, word captured but not yet valid
//   S_HOLD | word valid on the output, waiting for out_ready
module ex_stage_pipe #(
  parameter int          CTRL_W   = 17,
  parameter int          SO_LSB   = 14,
  parameter int          ALU_LSB  = 11,
  parameter int          LOAD_BIT = 10,
  parameter int          RFEN_BIT = 9,
  parameter int          BR_BIT   = 8,
  parameter logic [2:0]  MC_OP    = 3'b111,
  parameter int          MC_LAT   = 4
) (
  input  logic            clk,
  input  logic            reset,
  ex_stage_pipe_if.slave  bus
);

  localparam int CNT_W = $clog2(MC_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] word_q, word_d;

  logic in_ready_c;
  logic accept;
  logic in_is_mc;
  logic out_valid_c;

  // Flush blocks acceptance in the same cycle so a concurrent word is dropped.
  always_comb begin
    in_ready_c = 1'b0;
    if (!bus.flush) begin
      in_ready_c = (state_q == S_IDLE) || ((state_q == S_HOLD) && bus.out_ready);
    end
  end

  assign accept   = bus.in_valid && in_ready_c;
  assign in_is_mc = (bus.control_signals[ALU_LSB +: 3] == MC_OP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;

    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      word_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_EXEC: begin
          // Counter parks at 1 rather than wrapping once the countdown completes.
          if (cnt_q > CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          word_d  = '0;
        end
      endcase

      // Acceptance is only possible from IDLE or a draining HOLD, so it overrides both.
      if (accept) begin
        word_d = bus.control_signals;
        if (in_is_mc) begin
          state_d = S_EXEC;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = S_HOLD;
        end
      end
    end
  end

  assign out_valid_c = (state_q == S_HOLD);

  assign bus.in_ready            = in_ready_c;
  assign bus.out_valid           = out_valid_c;
  assign bus.busy                = (state_q == S_EXEC);
  assign bus.control_signals_out = word_q;

  assign bus.alu_op_out         = out_valid_c ? word_q[ALU_LSB +: 3] : 3'b000;
  assign bus.source_operand_out = out_valid_c ? word_q[SO_LSB +: 3]  : 3'b000;
  assign bus.load_instr_out     = out_valid_c && word_q[LOAD_BIT];
  assign bus.rf_enable_out      = out_valid_c && word_q[RFEN_BIT];
  assign bus.branch_out         = out_valid_c && word_q[BR_BIT];

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed and randomized checks of ex_stage_pipe against a transaction-level model
// that tracks the single in-flight word and its remaining wait cycles.
module tb_ex_stage_pipe;

  localparam int MC_LAT = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  ex_stage_pipe_if #(.CTRL_W(17)) bus ();

  ex_stage_pipe #(.CTRL_W(17), .MC_LAT(MC_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
  task automatic set_in(input logic iv, input logic [16:0] cs, input logic fl, input logic ordy);
    @(negedge clk);
    bus.in_valid        = iv;
    bus.control_signals = cs;
    bus.flush           = fl;
    bus.out_ready       = ordy;
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.control_signals = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL reset_valid_busy: got %b expected 00", {bus.out_valid, bus.busy});
    end
    checks++;
    if (bus.control_signals_out !== 17'h0) begin
      errors++; $display("FAIL reset_ctrl_out: got %h expected 0", bus.control_signals_out);
    end
    checks++;
    if ({bus.alu_op_out, bus.source_operand_out, bus.load_instr_out, bus.rf_enable_out, bus.branch_out} !== 9'd0) begin
      errors++; $display("FAIL reset_decoded: got %b expected 0",
        {bus.alu_op_out, bus.source_operand_out, bus.load_instr_out, bus.rf_enable_out, bus.branch_out});
    end
    @(negedge clk);
    reset = 1'b1;
    set_in(1'b0, 17'h0, 1'b0, 1'b1);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    set_in(1'b1, 17'h05A00, 1'b0, 1'b1);
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++; $display("FAIL basic_accept: got %b expected 10", {bus.in_ready, bus.out_valid});
    end
    set_in(1'b0, 17'h0, 1'b0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL basic_latency: out_valid got %b expected 1", bus.out_valid);
    end
    checks++;
    if ({bus.source_operand_out, bus.alu_op_out} !== 6'b001_011) begin
      errors++; $display("FAIL basic_fields: got %b expected 001011", {bus.source_operand_out, bus.alu_op_out});
    end
    checks++;
    if ({bus.rf_enable_out, bus.load_instr_out, bus.branch_out} !== 3'b100) begin
      errors++; $display("FAIL basic_bits: got %b expected 100",
        {bus.rf_enable_out, bus.load_instr_out, bus.branch_out});
    end
    set_in(1'b0, 17'h0, 1'b0, 1'b1);
    checks++;
    if ({bus.out_valid, bus.alu_op_out, bus.rf_enable_out} !== 5'b0) begin
      errors++; $display("FAIL basic_drain: got %b expected 00000", {bus.out_valid, bus.alu_op_out, bus.rf_enable_out});
    end
  endtask

  task automatic test_multicycle();
    set_in(1'b1, 17'h03900, 1'b0, 1'b1);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL mc_accept: in_ready got %b expected 1", bus.in_ready);
    end
    for (int i = 0; i < MC_LAT; i++) begin
      set_in(1'b1, 17'h1FFFF, 1'b0, 1'b1);
      checks++;
      if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b100) begin
        errors++; $display("FAIL mc_exec_cycle%0d: busy/in_ready/out_valid got %b expected 100",
          i, {bus.busy, bus.in_ready, bus.out_valid});
      end
      checks++;
      if (bus.control_signals_out !== 17'h03900) begin
        errors++; $display("FAIL mc_exec_word%0d: got %h expected 03900", i, bus.control_signals_out);
      end
    end
    set_in(1'b0, 17'h0, 1'b0, 1'b0);
    checks++;
    if ({bus.out_valid, bus.busy, bus.alu_op_out, bus.branch_out} !== 6'b10_111_1) begin
      errors++; $display("FAIL mc_done: valid/busy/alu/br got %b expected 101111",
        {bus.out_valid, bus.busy, bus.alu_op_out, bus.branch_out});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 17'h0ABCD, 1'b0, 1'b0);
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.alu_op_out, bus.branch_out} !== 6'b01_111_1 ||
          bus.control_signals_out !== 17'h03900) begin
        errors++; $display("FAIL stall_cycle%0d: rdy/valid/alu/br got %b word %h expected 011111 word 03900",
          i, {bus.in_ready, bus.out_valid, bus.alu_op_out, bus.branch_out}, bus.control_signals_out);
      end
    end
    set_in(1'b1, 17'h05A00, 1'b0, 1'b1);
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b11) begin
      errors++; $display("FAIL b2b_handoff: rdy/valid got %b expected 11", {bus.in_ready, bus.out_valid});
    end
    set_in(1'b0, 17'h0, 1'b0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.control_signals_out !== 17'h05A00 || bus.alu_op_out !== 3'b011) begin
      errors++; $display("FAIL b2b_no_bubble: valid %b word %h alu %b expected 1 05a00 011",
        bus.out_valid, bus.control_signals_out, bus.alu_op_out);
    end
    set_in(1'b0, 17'h0, 1'b0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: out_valid got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    set_in(1'b1, 17'h03900, 1'b0, 1'b1);
    set_in(1'b0, 17'h0, 1'b0, 1'b1);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL flush_exec1: busy got %b expected 1", bus.busy);
    end
    set_in(1'b1, 17'h05A00, 1'b1, 1'b1);
    checks++;
    if ({bus.busy, bus.in_ready} !== 2'b10) begin
      errors++; $display("FAIL flush_exec2: busy/in_ready got %b expected 10", {bus.busy, bus.in_ready});
    end
    set_in(1'b0, 17'h0, 1'b0, 1'b1);
    checks++;
    if ({bus.busy, bus.out_valid, bus.in_ready} !== 3'b001 || bus.control_signals_out !== 17'h0) begin
      errors++; $display("FAIL flush_after: busy/valid/rdy %b word %h expected 001 00000",
        {bus.busy, bus.out_valid, bus.in_ready}, bus.control_signals_out);
    end
    for (int i = 0; i < 6; i++) begin
      set_in(1'b0, 17'h0, 1'b0, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_no_emit%0d: out_valid got %b expected 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_async_reset();
    set_in(1'b1, 17'h05A00, 1'b0, 1'b0);
    set_in(1'b0, 17'h0, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL areset_hold: out_valid got %b expected 1", bus.out_valid);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.busy, bus.rf_enable_out, bus.alu_op_out, bus.source_operand_out} !== 9'd0 ||
        bus.control_signals_out !== 17'h0) begin
      errors++; $display("FAIL areset_immediate: outputs %b word %h expected 0 0",
        {bus.out_valid, bus.busy, bus.rf_enable_out, bus.alu_op_out, bus.source_operand_out},
        bus.control_signals_out);
    end
    @(negedge clk);
    reset = 1'b1;
    set_in(1'b1, 17'h05A00, 1'b0, 1'b1);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL areset_ready: in_ready got %b expected 1", bus.in_ready);
    end
    set_in(1'b0, 17'h0, 1'b0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.control_signals_out !== 17'h05A00) begin
      errors++; $display("FAIL areset_relaunch: valid %b word %h expected 1 05a00",
        bus.out_valid, bus.control_signals_out);
    end
  endtask

  task automatic test_random();
    logic        m_has;
    logic [16:0] m_word;
    int          m_wait;
    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];
    logic        iv, fl, ordy, exp_rdy, exp_ov, exp_busy;
    logic [16:0] cs;
    logic [8:0]  exp_dec, obs_dec;
    int          n;

    set_in(1'b0, 17'h0, 1'b1, 1'b1);
    m_has = 1'b0; m_word = '0; m_wait = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      iv   = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 39) == 0);
      ordy = ($urandom_range(0, 9) < 6);
      cs   = 17'($urandom);
      if ($urandom_range(0, 3) == 0) cs[13:11] = 3'b111;
      set_in(iv, cs, fl, ordy);

      exp_ov   = m_has && (m_wait == 0);
      exp_busy = m_has && (m_wait > 0);
      exp_rdy  = !fl && (!m_has || (exp_ov && ordy));
      exp_dec  = exp_ov ? {m_word[16:14], m_word[13:11], m_word[10], m_word[9], m_word[8]} : 9'd0;
      obs_dec  = {bus.source_operand_out, bus.alu_op_out, bus.load_instr_out, bus.rf_enable_out, bus.branch_out};

      checks++;
      if ({bus.in_ready, bus.out_valid, bus.busy} !== {exp_rdy, exp_ov, exp_busy}) begin
        errors++; $display("FAIL rand_ctrl cyc%0d: rdy/valid/busy got %b expected %b",
          cyc, {bus.in_ready, bus.out_valid, bus.busy}, {exp_rdy, exp_ov, exp_busy});
      end
      checks++;
      if (obs_dec !== exp_dec) begin
        errors++; $display("FAIL rand_decode cyc%0d: got %b expected %b", cyc, obs_dec, exp_dec);
      end
      if (m_has) begin
        checks++;
        if (bus.control_signals_out !== m_word) begin
          errors++; $display("FAIL rand_word cyc%0d: got %h expected %h", cyc, bus.control_signals_out, m_word);
        end
      end

      if (bus.out_valid === 1'b1 && ordy && !fl) obs_q.push_back(bus.control_signals_out);

      if (fl) begin
        m_has = 1'b0;
      end else begin
        if (exp_ov && ordy) begin
          exp_q.push_back(m_word);
          m_has = 1'b0;
        end else if (exp_busy) begin
          m_wait--;
        end
        if (iv && exp_rdy) begin
          m_has  = 1'b1;
          m_word = cs;
          m_wait = (cs[13:11] == 3'b111) ? MC_LAT : 0;
        end
      end
    end

    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: emitted %0d words expected %0d", obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_order idx%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multicycle();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage_pipe.md
EX_STAGE_PIPE -- requirements
Module: ex_stage_pipe

Interface
REQ-001 Parameter CTRL_W, default 17: control-word width.
REQ-002 Parameter SO_LSB, default 14: LSB of the 3-bit source-operand field.
REQ-003 Parameter ALU_LSB, default 11: LSB of the 3-bit ALU-op field.
REQ-004 Parameters LOAD_BIT/RFEN_BIT/BR_BIT, defaults 10/9/8: load, register-file-enable and branch bit positions.
REQ-005 Parameter MC_OP, default 3'b111: ALU-op code marking a multi-cycle operation.
REQ-006 Parameter MC_LAT, default 4, legal range >= 2: multi-cycle latency in cycles.
REQ-007 clk  in  1  single clock; all state changes on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 in_valid  in  1  upstream presents a control word.
REQ-010 in_ready  out  1  block accepts the word this cycle.
REQ-011 control_signals  in  CTRL_W  incoming control word.
REQ-012 flush  in  1  synchronous squash of the held or executing word.
REQ-013 out_valid  out  1  control_signals_out holds a valid word.
REQ-014 out_ready  in  1  downstream consumes the word this cycle.
REQ-015 control_signals_out  out  CTRL_W  held control word.
REQ-016 alu_op_out / source_operand_out  out  3 / 3  decoded fields of the held word.
REQ-017 load_instr_out / rf_enable_out / branch_out  out  1 each  decoded bits of the held word.
REQ-018 busy  out  1  multi-cycle execution in progress.

Function
REQ-019 The block SHALL implement states IDLE (empty), EXEC (multi-cycle countdown) and HOLD (word valid).
REQ-020 The block SHALL accept a word only on a cycle where in_valid=1 and in_ready=1.
REQ-021 in_ready SHALL be 1 in IDLE, equal out_ready in HOLD, and be 0 in EXEC or while flush=1.
REQ-022 IDLE: on acceptance of a word whose ALU-op is not MC_OP, the block SHALL go to HOLD with out_valid=1 on the next cycle (1-cycle latency).
REQ-023 IDLE: on acceptance of an MC_OP word, the block SHALL go to EXEC, load a counter with MC_LAT and assert busy.
REQ-024 EXEC: the counter SHALL decrement each cycle; on the edge where it equals 1, the state SHALL become HOLD, so out_valid rises exactly MC_LAT cycles after acceptance.
REQ-025 The counter SHALL be $clog2(MC_LAT+1) bits wide and SHALL never wrap below 1.
REQ-026 HOLD with out_ready=0: control_signals_out and all decoded outputs SHALL remain stable.
REQ-027 HOLD with out_ready=1 and no acceptance: the state SHALL become IDLE and out_valid SHALL drop next cycle.
REQ-028 HOLD with out_ready=1 and a simultaneous acceptance: the new word SHALL replace the held one with no bubble, and the next state SHALL follow REQ-022/023.
REQ-029 busy SHALL be 1 exactly while in EXEC.
REQ-030 Decoded outputs SHALL be taken from the held word and SHALL be forced to 0 whenever out_valid=0.
REQ-031 control_signals_out SHALL be updated with the captured word at acceptance; in EXEC it SHALL hold that word while out_valid=0.
REQ-032 flush=1 SHALL take priority over every other event and, at the next edge, SHALL do all of the following: go to IDLE, clear out_valid, busy and the counter, set control_signals_out to 0, and drop any concurrent input word.

Reset
REQ-033 While reset=0, the block SHALL asynchronously enter IDLE with out_valid, busy, the counter, control_signals_out and all decoded outputs at 0.
REQ-034 After reset deasserts, in_ready SHALL be 1 in the first cycle; reset asserted during EXEC or HOLD SHALL abandon the word.

Verification
REQ-035 Reset, then present 17'h05A00 with in_valid=1 and out_ready=1 -> next cycle out_valid=1, source_operand_out=3'b001, alu_op_out=3'b011, rf_enable_out=1, load_instr_out=0, branch_out=0.
REQ-036 Accept 17'h03900 (MC_OP, branch set) -> busy=1 and in_ready=0 for 4 cycles, then out_valid=1, alu_op_out=3'b111, branch_out=1.
REQ-037 Hold out_ready=0 for 5 cycles in HOLD -> outputs stable and in_ready=0 throughout; raise out_ready together with in_valid -> back-to-back transfer with no bubble.
REQ-038 Assert flush in the 2nd EXEC cycle -> next cycle IDLE, busy=0, out_valid=0, control_signals_out=0, and the MC word is never emitted.
REQ-039 Drive reset=0 asynchronously mid-HOLD (between clock edges) -> outputs go to 0 immediately, and the next word after release completes with 1-cycle latency.
REQ-040 Run a randomized stream with random in_valid/out_ready/flush -> a scoreboard sees every unflushed word exactly once, in order, and no word emitted after its flush.
